// File: rtl/ds_pkg.sv
// ds_pkg
// Shared definitions for the delta-sigma input path.
//   IN_BITS_DEFAULT : default sample width, shared with the modulator
//   feeder_state_t  : ds_sample_feeder sequencing states
package ds_pkg;

  localparam int IN_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/ds_sample_feeder_if.sv
// ds_sample_feeder_if
// Host/modulator side bundle of ds_sample_feeder.
//   master : host/modulator side (drives start, stop, in_data, in_valid, ds_consume)
//   slave  : the feeder (drives in_ready, u, ds_run, ds_reset_lfsr, busy,
//            underflow, underflow_count)
interface ds_sample_feeder_if
  import ds_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEFAULT,
  parameter int CNT_BITS = 8
);
  logic                start;
  logic                stop;
  logic [IN_BITS-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic                ds_consume;
  logic [IN_BITS-1:0]  u;
  logic                ds_run;
  logic                ds_reset_lfsr;
  logic                busy;
  logic                underflow;
  logic [CNT_BITS-1:0] underflow_count;

  modport master (
    output start, stop, in_data, in_valid, ds_consume,
    input  in_ready, u, ds_run, ds_reset_lfsr, busy, underflow, underflow_count
  );

  modport slave (
    input  start, stop, in_data, in_valid, ds_consume,
    output in_ready, u, ds_run, ds_reset_lfsr, busy, underflow, underflow_count
  );
endinterface

// File: rtl/ds_sample_fifo.sv
// ds_sample_fifo
// Synchronous FIFO, DEPTH entries (power of two, >= 2) of DATA_W bits.
//   push/push_data : write when push && !full
//   pop            : read when pop && !empty; head is the oldest entry
//   occupancy      : entry count, clog2(DEPTH)+1 bits
//   full/empty     : decoded from the registered occupancy
// Only pointers and occupancy are reset; storage contents are don't-care.
module ds_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == OCC_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ds_sample_feeder.sv
// ds_sample_feeder
// Feeds host samples to the delta-sigma modulator: buffers them in a FIFO,
// holds u stable and advances it once per modulator sample boundary
// (ds_consume), sequences run/stop and the LFSR reset pulse, and flags
// underflow when a boundary arrives with nothing buffered.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : ds_sample_feeder_if.slave (start/stop, in_* handshake,
//                ds_consume, u, ds_run, ds_reset_lfsr, busy, underflow,
//                underflow_count)
// Build option: DS_FEEDER_UNDERFLOW_CNT_EN enables the saturating
// underflow counter; otherwise underflow_count is tied to zero.
module ds_sample_feeder
  import ds_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  ds_sample_feeder_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  feeder_state_t      state, state_next;
  logic [IN_BITS-1:0] head;
  logic [OCC_W-1:0]   fifo_occ;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               lfsr_next;
  logic               prime_load;
  logic               consume_upd;
  logic               uf_hit;

  logic [IN_BITS-1:0] u_reg;
  logic               ds_run_reg;
  logic               lfsr_reg;
  logic               busy_reg;
  logic               underflow_reg;

  // in_ready depends only on registered occupancy, never on this cycle's pop.
  assign bus.in_ready = (fifo_occ < OCC_W'(DEPTH));
  assign push         = bus.in_valid && !fifo_full;

  ds_sample_fifo #(
    .DATA_W (IN_BITS),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (head),
    .occupancy (fifo_occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next  = state;
    lfsr_next   = 1'b0;
    prime_load  = 1'b0;
    consume_upd = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next = PRIME;
          lfsr_next  = 1'b1;
        end
      end
      PRIME: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (!fifo_empty) begin
          prime_load = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        consume_upd = bus.ds_consume;
        if (bus.stop) state_next = STOPPING;
      end
      STOPPING: begin
        consume_upd = bus.ds_consume;
        if (bus.ds_consume) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop    = prime_load || (consume_upd && !fifo_empty);
  assign uf_hit = consume_upd && fifo_empty;

  // Control outputs are registered from next-state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      u_reg         <= '0;
      ds_run_reg    <= 1'b0;
      lfsr_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state         <= state_next;
      ds_run_reg    <= (state_next == RUN) || (state_next == STOPPING);
      busy_reg      <= (state_next != IDLE);
      lfsr_reg      <= lfsr_next;
      underflow_reg <= uf_hit;
      if (pop) u_reg <= head;
    end
  end

  assign bus.u             = u_reg;
  assign bus.ds_run        = ds_run_reg;
  assign bus.ds_reset_lfsr = lfsr_reg;
  assign bus.busy          = busy_reg;
  assign bus.underflow     = underflow_reg;

`ifdef DS_FEEDER_UNDERFLOW_CNT_EN
  logic [CNT_BITS-1:0] uf_count;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      uf_count <= '0;
    end else if (uf_hit) begin
      uf_count <= sat_inc(uf_count);
    end
  end

  assign bus.underflow_count = uf_count;
`else
  assign bus.underflow_count = '0;
`endif
endmodule

// File: tb/tb_ds_sample_feeder.sv
// tb_ds_sample_feeder
// Self-checking bench for ds_sample_feeder (DEPTH=4, IN_BITS=16, CNT_BITS=8).
// Accepted host samples go into a scoreboard queue; each sample boundary
// while running pops the expected u. A table drives the fill/drain pattern.
module tb_ds_sample_feeder;
  import ds_pkg::*;

  localparam int IB = 16;
  localparam int DP = 4;
  localparam int CB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ds_sample_feeder_if #(.IN_BITS(IB), .CNT_BITS(CB)) bus ();

  ds_sample_feeder #(
    .IN_BITS  (IB),
    .DEPTH    (DP),
    .CNT_BITS (CB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [IB-1:0] d;
    logic          c;
    logic          rdy;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [IB-1:0] q[$];
  logic          running;
  logic [IB-1:0] last_u;
  int            ufc;
  vec_t          tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef DS_FEEDER_UNDERFLOW_CNT_EN
    return 32'(ufc);
`else
    return 32'd0;
`endif
  endfunction

  // One clock: drive, predict, step, check u/underflow.
  task automatic cyc(input logic v, input logic [IB-1:0] d, input logic c,
                     input logic st, input logic sp);
    logic          acc;
    logic          popx;
    logic          ufx;
    logic [IB-1:0] eu;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.ds_consume = c;
    bus.start      = st;
    bus.stop       = sp;
    acc  = v && bus.in_ready;
    popx = c && running && (q.size() > 0);
    ufx  = c && running && (q.size() == 0);
    eu   = last_u;
    if (popx) eu = q.pop_front();
    if (acc) q.push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.ds_consume = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    if (c && running) chk("u_update", 32'(bus.u), 32'(eu));
    last_u = eu;
    chk("underflow", 32'(bus.underflow), 32'(ufx));
    if (ufx) ufc = (ufc == 255) ? 255 : ufc + 1;
  endtask

  task automatic push(input logic [IB-1:0] d);
    chk("in_ready_push", 32'(bus.in_ready), 32'd1);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    logic [IB-1:0] eu;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_lfsr", 32'(bus.ds_reset_lfsr), 32'd1);
    chk("start_run_low", 32'(bus.ds_run), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("prime_lfsr_low", 32'(bus.ds_reset_lfsr), 32'd0);
    chk("prime_run", 32'(bus.ds_run), 32'd1);
    eu = q.pop_front();
    chk("prime_u", 32'(bus.u), 32'(eu));
    last_u  = eu;
    running = 1'b1;
  endtask

  task automatic check_reset();
    chk("rst_u", 32'(bus.u), 32'd0);
    chk("rst_run", 32'(bus.ds_run), 32'd0);
    chk("rst_lfsr", 32'(bus.ds_reset_lfsr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
    chk("rst_count", 32'(bus.underflow_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.ds_consume = 1'b0;
    running = 1'b0; last_u = '0; ufc = 0;

    // Fill/drain with full-FIFO push+consume collisions; rdy is the
    // in_ready expected during that cycle.
    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 16'h0004, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 16'h0005, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0005, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'h0005, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 16'h0006, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset();

    // First sample reaches u two cycles after start.
    push(16'h1234);
    do_start();
    chk("empty_after_start", 32'(bus.in_ready), 32'd1);

    // Underflow while running: u holds.
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("uf_u_hold", 32'(bus.u), 32'h1234);
    chk("uf_count3", 32'(bus.underflow_count), exp_cnt());

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      cyc(tbl[i].v, tbl[i].d, tbl[i].c, 1'b0, 1'b0);
    end

    // start while running is ignored.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("start_ignored_lfsr", 32'(bus.ds_reset_lfsr), 32'd0);
    chk("start_ignored_busy", 32'(bus.busy), 32'd1);

    // stop, then a boundary five cycles later.
    push(16'h00A1);
    push(16'h00A2);
    push(16'h00A3);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("stopping_run", 32'(bus.ds_run), 32'd1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    chk("stopping_run_last", 32'(bus.ds_run), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    running = 1'b0;
    chk("stopped_run", 32'(bus.ds_run), 32'd0);
    chk("stopped_busy", 32'(bus.busy), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("idle_consume_u", 32'(bus.u), 32'h00A1);
    do_start();

    // Drive the counter to saturation.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    while (ufc < 255) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("count_255", 32'(bus.underflow_count), exp_cnt());
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("count_sat", 32'(bus.underflow_count), exp_cnt());

    // Reset mid-run drops pending start/stop and flushes the FIFO.
    push(16'h0077);
    push(16'h0088);
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_reset();
    reset = 1'b0;
    q.delete();
    running = 1'b0; last_u = '0; ufc = 0;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    // stop in PRIME returns to IDLE without a pop.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("prime_wait_busy", 32'(bus.busy), 32'd1);
    chk("prime_wait_run", 32'(bus.ds_run), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("prime_stop_busy", 32'(bus.busy), 32'd0);
    push(16'h0055);
    do_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
